// File: rtl/gen_delay_bank.sv
// gen_delay_bank: CHANNELS independent lanes. Each lane is WIDTH bits wide and
// passes through DEPTH registered stages. Every stage carries a valid tag.
// The bank supports a global stall (hold), a synchronous flush and a busy flag.
// Optional feature macro: GEN_DELAY_PARITY_EN. When it is defined, each stage
// also stores an even-parity bit and drives a sticky per-lane parity error.
// When it is undefined, parity_err is tied to 0 and inj_err is unused.
module gen_delay_bank #(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 1,
   parameter int DEPTH    = 1
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      hold,
   input  logic                      flush,
   input  logic                      inj_err,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       out_valid,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      busy,
   output logic [CHANNELS-1:0]       parity_err
);

   logic [CHANNELS-1:0] lane_busy;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
         logic [DEPTH-1:0] valid_reg;
         logic [WIDTH-1:0] data_reg [DEPTH];
         logic [WIDTH-1:0] data_next;

         // Invalid entries always enter the pipe with zero data.
         assign data_next = in_valid[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;

         // Lane shift register: flush has priority over hold, and hold over shift.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               valid_reg <= '0;
               for (int k = 0; k < DEPTH; k++) data_reg[k] <= '0;
            end else if (flush) begin
               valid_reg <= '0;
               for (int k = 0; k < DEPTH; k++) data_reg[k] <= '0;
            end else if (!hold) begin
               valid_reg[0] <= in_valid[gi];
               data_reg[0]  <= data_next;
               for (int k = 1; k < DEPTH; k++) begin
                  valid_reg[k] <= valid_reg[k-1];
                  data_reg[k]  <= data_reg[k-1];
               end
            end
         end

         assign out_valid[gi]                  = valid_reg[DEPTH-1];
         assign out_data[gi*WIDTH +: WIDTH]    = data_reg[DEPTH-1];
         assign lane_busy[gi]                  = |valid_reg;

`ifdef GEN_DELAY_PARITY_EN
         logic [DEPTH-1:0] par_reg;
         logic             par_next;
         logic             perr_reg;
         logic             mismatch;

         // Even parity of the captured word. It is inverted on injection for valid words only.
         assign par_next = (^data_next) ^ (inj_err & in_valid[gi]);
         assign mismatch = valid_reg[DEPTH-1] & ((^data_reg[DEPTH-1]) != par_reg[DEPTH-1]);

         // Parity bits move through the pipe in lockstep with the data stages.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               par_reg <= '0;
            end else if (flush) begin
               par_reg <= '0;
            end else if (!hold) begin
               par_reg[0] <= par_next;
               for (int k = 1; k < DEPTH; k++) par_reg[k] <= par_reg[k-1];
            end
         end

         // Sticky mismatch flag for the word in the last stage. It clears only on flush or reset.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               perr_reg <= 1'b0;
            end else if (flush) begin
               perr_reg <= 1'b0;
            end else if (mismatch) begin
               perr_reg <= 1'b1;
            end
         end

         assign parity_err[gi] = perr_reg;
`else
         assign parity_err[gi] = 1'b0;
`endif
      end
   endgenerate

`ifndef GEN_DELAY_PARITY_EN
   logic unused_inj_err;
   assign unused_inj_err = inj_err;
`endif

   assign busy = |lane_busy;

endmodule

// File: tb/tb_gen_delay_bank.sv
// Directed testbench for gen_delay_bank. It uses three instances with different
// geometries: DEPTH=1 bit lanes, a 4x8 bank with DEPTH=3, and a 2x8 bank with DEPTH=4.
module tb_gen_delay_bank;

   logic clock = 1'b0;
   logic rst_n = 1'b1;
   int   vecs  = 0;
   int   errs  = 0;

   // Instance d1: CHANNELS=2, WIDTH=1, DEPTH=1
   logic [1:0] d1_iv = '0, d1_id = '0, d1_ov, d1_od, d1_pe;
   logic       d1_busy;
   // Instance d3: CHANNELS=4, WIDTH=8, DEPTH=3
   logic [3:0]  d3_iv = '0, d3_ov, d3_pe;
   logic [31:0] d3_id = '0, d3_od;
   logic        d3_flush = 1'b0, d3_inj = 1'b0, d3_busy;
   // Instance d4: CHANNELS=2, WIDTH=8, DEPTH=4
   logic [1:0]  d4_iv = '0, d4_ov, d4_pe;
   logic [15:0] d4_id = '0, d4_od;
   logic        d4_hold = 1'b0, d4_flush = 1'b0, d4_busy;

`ifdef GEN_DELAY_PARITY_EN
   localparam logic [3:0] PERR_EXP = 4'b0100;
`else
   localparam logic [3:0] PERR_EXP = 4'b0000;
`endif

   gen_delay_bank #(.CHANNELS(2), .WIDTH(1), .DEPTH(1)) u_d1 (
      .clock(clock), .reset_n(rst_n), .hold(1'b0), .flush(1'b0), .inj_err(1'b0),
      .in_valid(d1_iv), .in_data(d1_id), .out_valid(d1_ov), .out_data(d1_od),
      .busy(d1_busy), .parity_err(d1_pe));

   gen_delay_bank #(.CHANNELS(4), .WIDTH(8), .DEPTH(3)) u_d3 (
      .clock(clock), .reset_n(rst_n), .hold(1'b0), .flush(d3_flush), .inj_err(d3_inj),
      .in_valid(d3_iv), .in_data(d3_id), .out_valid(d3_ov), .out_data(d3_od),
      .busy(d3_busy), .parity_err(d3_pe));

   gen_delay_bank #(.CHANNELS(2), .WIDTH(8), .DEPTH(4)) u_d4 (
      .clock(clock), .reset_n(rst_n), .hold(d4_hold), .flush(d4_flush), .inj_err(1'b0),
      .in_valid(d4_iv), .in_data(d4_id), .out_valid(d4_ov), .out_data(d4_od),
      .busy(d4_busy), .parity_err(d4_pe));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Stream table for d4: inputs before each edge and expected outputs after it.
   logic        st_v [10] = '{1,1,1,1,1,1,0,0,0,0};
   logic [7:0]  st_d [10] = '{8'd1,8'd2,8'd99,8'd99,8'd3,8'd4,8'h55,8'h55,8'h55,8'h55};
   logic        st_h [10] = '{0,0,1,1,0,0,0,0,0,0};
   logic        ex_v [10] = '{0,0,0,0,0,1,1,1,1,0};
   logic [7:0]  ex_d [10] = '{8'd0,8'd0,8'd0,8'd0,8'd0,8'd1,8'd2,8'd3,8'd4,8'd0};
   logic        ex_b [10] = '{1,1,1,1,1,1,1,1,1,0};

   initial begin
      // Reset is asserted with live inputs on d1. All outputs must stay 0 across an edge.
      #1;
      rst_n = 1'b0;
      d1_iv = 2'b11;
      d1_id = 2'b10;
      step();
      chk("rst_d1_ov", d1_ov, 2'b00);
      chk("rst_d1_od", d1_od, 2'b00);
      chk("rst_d1_busy", d1_busy, 1'b0);
      chk("rst_d3_ov", d3_ov, 4'h0);
      chk("rst_d3_od", d3_od, 32'h0);
      chk("rst_d4_busy", d4_busy, 1'b0);
      chk("rst_d3_pe", d3_pe, 4'h0);
      rst_n = 1'b1;

      // d1 (DEPTH=1): output follows input one edge later. The toggle pattern is 10, 01, 10, ...
      step();
      chk("d1_ov0", d1_ov, 2'b11);
      chk("d1_od0", d1_od, 2'b10);
      for (int i = 0; i < 4; i++) begin
         d1_id = (i % 2 == 0) ? 2'b01 : 2'b10;
         step();
         chk("d1_ov", d1_ov, 2'b11);
         chk("d1_od", d1_od, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      d1_iv = 2'b00;
      step();
      chk("d1_drain_ov", d1_ov, 2'b00);
      chk("d1_drain_od", d1_od, 2'b00);

      // d3 (DEPTH=3): lane 2 sends 0xA5 once, with inj_err set. Garbage data arrives while invalid.
      d3_iv  = 4'b0100;
      d3_id  = 32'h00A5_0000;
      d3_inj = 1'b1;
      step();
      d3_iv  = 4'b0000;
      d3_id  = 32'hFFFF_FFFF;
      d3_inj = 1'b0;
      chk("d3_e1_ov", d3_ov, 4'b0000);
      chk("d3_e1_busy", d3_busy, 1'b1);
      step();
      chk("d3_e2_ov", d3_ov, 4'b0000);
      chk("d3_e2_busy", d3_busy, 1'b1);
      step();
      chk("d3_e3_ov", d3_ov, 4'b0100);
      chk("d3_e3_od", d3_od, 32'h00A5_0000);
      chk("d3_e3_busy", d3_busy, 1'b1);
      chk("d3_e3_pe", d3_pe, 4'b0000);
      step();
      chk("d3_e4_ov", d3_ov, 4'b0000);
      chk("d3_e4_od", d3_od, 32'h0);
      chk("d3_e4_busy", d3_busy, 1'b0);
      chk("d3_e4_pe", d3_pe, PERR_EXP);
      step();
      chk("d3_e5_pe_sticky", d3_pe, PERR_EXP);
      d3_flush = 1'b1;
      step();
      d3_flush = 1'b0;
      chk("d3_flush_pe", d3_pe, 4'b0000);
      d3_id = 32'h0;

      // d4 (DEPTH=4): lane 0 streams 1,2,3,4 with two hold cycles in the middle of the stream.
      for (int i = 0; i < 10; i++) begin
         d4_iv   = {1'b0, st_v[i]};
         d4_id   = {8'h00, st_d[i]};
         d4_hold = st_h[i];
         step();
         chk("d4_stream_ov", d4_ov, {1'b0, ex_v[i]});
         chk("d4_stream_od", d4_od, {8'h00, ex_d[i]});
         chk("d4_stream_busy", d4_busy, ex_b[i]);
      end

      // d4: fill the pipe, then apply flush together with hold and valid input.
      d4_iv = 2'b11;
      d4_id = 16'h2211;
      for (int i = 0; i < 4; i++) step();
      chk("d4_full_ov", d4_ov, 2'b11);
      chk("d4_full_od", d4_od, 16'h2211);
      d4_flush = 1'b1;
      d4_hold  = 1'b1;
      d4_id    = 16'hEEEE;
      step();
      d4_flush = 1'b0;
      d4_hold  = 1'b0;
      d4_iv    = 2'b00;
      d4_id    = 16'h0;
      chk("d4_flush_ov", d4_ov, 2'b00);
      chk("d4_flush_od", d4_od, 16'h0);
      chk("d4_flush_busy", d4_busy, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("d4_postflush_ov", d4_ov, 2'b00);
         chk("d4_postflush_busy", d4_busy, 1'b0);
      end

      // d4: fill the pipe again, then pulse reset between edges. Outputs must drop at once.
      d4_iv = 2'b11;
      d4_id = 16'h4433;
      for (int i = 0; i < 4; i++) step();
      chk("d4_refill_ov", d4_ov, 2'b11);
      d4_iv = 2'b00;
      d4_id = 16'h0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ov", d4_ov, 2'b00);
      chk("async_rst_od", d4_od, 16'h0);
      chk("async_rst_busy", d4_busy, 1'b0);
      rst_n = 1'b1;
      step();
      chk("post_rst_ov", d4_ov, 2'b00);
      chk("post_rst_busy", d4_busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/gen_delay_bank.md
# gen_delay_bank

Parametrised multi-channel delay line: CHANNELS independent lanes, each WIDTH bits wide, each delayed by DEPTH registered stages that carry a valid tag. It generalises the single-bit, single-stage per-lane register array built by a generate loop, adding:
- configurable width and depth
- a global stall, a synchronous flush and a busy indicator
- optional parity protection

It sits between generated per-channel producers and consumers that need deterministic, equal latency across lanes.

## Interface
- CHANNELS, 2, number of independent lanes (1..32)
- WIDTH, 1, data bits per lane (1..64)
- DEPTH, 1, register stages per lane; latency in cycles (1..16)

- clock  in  1  rising-edge clock for all state
- reset_n  in  1  asynchronous, active-low reset
- hold  in  1  global stall; all stages keep their contents
- flush  in  1  synchronous clear of all valid tags and data
- inj_err  in  1  parity error injection; ignored unless GEN_DELAY_PARITY_EN
- in_valid  in  CHANNELS  per-lane input qualifier
- in_data  in  CHANNELS*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- out_valid  out  CHANNELS  valid tag of last stage, per lane
- out_data  out  CHANNELS*WIDTH  data of last stage, same packing as in_data
- busy  out  1  OR of every valid tag in every stage of every lane
- parity_err  out  CHANNELS  sticky per-lane parity mismatch flag

## Operation
- One generate loop produces CHANNELS identical lanes. Lanes share only clock, reset_n, hold, flush and inj_err.
- Each lane is a DEPTH-deep shift register of {valid, data} entries (plus a parity bit when enabled).
- Priority per rising edge: reset_n low > flush > hold > shift.
- Shift (hold=0, flush=0):
  - stage0 <= {in_valid[i], in_valid[i] ? in_data lane i : 0}
  - stage k <= stage k-1
  - Invalid entries always store zero data.
- hold=1, flush=0: every stage of every lane holds. in_valid and in_data are ignored and not captured.
- flush=1: every stage of every lane becomes {0, 0}. Input presented in the same cycle is discarded. parity_err clears.
- out_valid and out_data are driven directly from the last-stage registers, with no combinational path from the inputs.
- busy is combinational from the stage registers only.
- Lanes are fully independent. Valid and invalid entries interleave freely; there are no bubbles and no compaction.

## Timing
- Reset values: out_valid=0, out_data=0, busy=0, parity_err=0; all internal stages are zero.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, i.e. valid during the cycle following edge N+DEPTH-1. With DEPTH=1, output follows input by one edge.
- Each cycle with hold=1 in flight adds exactly one cycle to the latency of every word.
- Throughput: one word per lane per non-held cycle.
- Reset asserted mid-operation: all in-flight words are lost immediately, without waiting for a clock edge.
- After reset_n rises, the first capture happens at the next rising edge.
- flush and hold asserted together: flush wins; pipeline empty after the edge.
- busy falls on the edge on which the last valid entry leaves the last stage or is flushed.

## Configuration
- Macro: GEN_DELAY_PARITY_EN.
- Defined:
  - Each stage carries an even-parity bit computed at stage0 from the captured data.
  - When inj_err=1 at capture, the stored parity bit is inverted for every lane whose in_valid=1.
  - At the last stage, if out_valid[i]=1 and the recomputed parity ≠ the stored parity, parity_err[i] is set on the next edge.
  - parity_err stays set until flush or reset.
  - Parity bits follow the same hold and flush rules as the data.
- Undefined:
  - No parity storage is present.
  - parity_err is tied to 0 and inj_err is unused.
  - All other behaviour is identical.

## Test plan
- Reset, CHANNELS=2, WIDTH=1, DEPTH=1, lane inputs a=2'b10 every cycle, toggle pattern -> out_data tracks in_data one edge later; out_valid=2'b11; outputs are 0 while reset_n=0.
- CHANNELS=4, WIDTH=8, DEPTH=3, lane 2 sends 0xA5 once -> out_valid=4'b0100 and lane 2 data=0xA5 exactly 3 edges later for one cycle; other lanes read 0; busy high for 3 cycles.
- DEPTH=4, stream 1,2,3,4 on lane 0, hold=1 for 2 cycles mid-stream -> outputs 1,2,3,4 contiguous, delayed by 2 extra cycles; no duplication or loss.
- DEPTH=4, pipeline full, flush=1 with hold=1 and in_valid=1 -> after the edge out_valid=0, busy=0; the flushed-cycle input never appears.
- Pipeline full, reset_n pulsed low between edges -> outputs drop to 0 immediately, before the next clock edge.
- With GEN_DELAY_PARITY_EN, inj_err=1 with lane 1 valid, DEPTH=2 -> parity_err=2'b10 one edge after that word exits; stays set until flush, then 0.
